clock_display_mux: RTL and testbench
====================================

Name: clock_display_mux

Overview:
- Downstream display stage for the 1 Hz digital clock.
- Captures the clock's binary minutes and seconds (0-59 each) on a load strobe and converts each to two BCD digits with an iterative subtract-10 FSM.
- Drives a 4-digit, common-anode, multiplexed seven-segment display as MM:SS.
- Sits between the clock counter and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit is enabled before the scan advances (1 ms at 50 MHz). Must be ≥2.
- CNT_W, $clog2(REFRESH_DIV): width of the refresh counter. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; capture minutes/seconds.
- minutes  in  6  binary minutes, 0-59 valid.
- seconds  in  6  binary seconds, 0-59 valid.
- sec_tick  in  1  1 Hz single-cycle pulse from the clock stage.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- an  out  4  digit enables, active-low, one-hot-zero; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE, busy=0, done=0.
  - All four digit registers = 0.
  - Scan index = 0, refresh count = 0.
  - an=4'b1110, seg=7'b1000000 ("0"), dp_n=1.
- FSM states: IDLE, CONV_MIN, CONV_SEC, COMMIT.
- IDLE:
  - On load=1, register minutes and seconds into shadow registers, load the work register with minutes, clear tens, go to CONV_MIN, set busy=1.
  - load while busy=1 is ignored; no queuing.
- CONV_MIN, once per cycle:
  - If work ≥ 10: work -= 10, tens += 1.
  - Else: store m_tens and m_ones = work[3:0], load work with seconds, clear tens, go to CONV_SEC.
- CONV_SEC: same rule; on exit store s_tens and s_ones, go to COMMIT.
- COMMIT:
  - Write all four display digit registers atomically; the display never shows a mixed old/new value.
  - done=1 for this cycle only, busy=0, return to IDLE.
- Latency from the load edge to done high: (floor(m/10)+1) + (floor(s/10)+1) + 1 cycles. 00:00 takes 3 cycles; 59:59 takes 13.
- Out of range (>59): decide per field, using the captured value.
  - Both digits of that field commit as code 4'hF, which displays dash (seg=7'b0111111).
  - The conversion still runs its normal cycle count, with the work value clamped so it takes at most 6 cycles per field.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the scan index increments 0→1→2→3→0.
  - Index 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens.
- Outputs an, seg and dp_n are registered. They reflect the new index one cycle after the wrap.
- A commit changes seg no later than one cycle after COMMIT, for whichever digit is currently active.
- Reset during a conversion: the FSM aborts to IDLE and the digits return to 0. There is no done pulse.
- Without the optional feature, sec_tick is ignored and dp_n is held at 1.

Optional Feature:
- Macro: DP_BLINK_EN.
- Defined:
  - A colon flag resets to 0 and toggles on each sec_tick pulse.
  - dp_n=0 only while scan index = 2 and the colon flag = 1. Otherwise dp_n=1.
- Undefined: the colon flag logic is absent and dp_n is tied to 1.

Decomposition:
- Package clock_disp_pkg holds:
  - The FSM state enum.
  - Segment constants SEG_0..SEG_9, SEG_DASH=7'b0111111, SEG_BLANK=7'b1111111.
  - DIGIT_DASH=4'hF.
- One natural sub-module: seg7_decode, a combinational 4-bit → 7-bit active-low map.
  - Codes 0-9 map to digits, 4'hF maps to dash, others map to blank.
  - Instantiated once, on the muxed digit.

Test Plan:
1. Reset: rst_n=0 then 1 → an=1110, seg=1000000, dp_n=1, busy=0, done=0.
2. Normal conversion: load with minutes=59, seconds=7 → busy high for 7 cycles, done on the 8th cycle. Digits read 5,9,0,7: index 3 shows seg=0010010, index 0 shows seg=1111000.
3. Load while busy: during case 2, pulse load with 45/30 → ignored; the final digits are still 59:07 and there is exactly one done pulse.
4. Out of range: load with minutes=60, seconds=0 → minute digits show 0111111; seconds show 0,0.
5. Scan timing: REFRESH_DIV=4 → an cycles 1110, 1101, 1011, 0111, 1110, each held 4 clocks.
6. Reset mid-conversion and colon blink:
   - Assert rst_n=0 in CONV_SEC → busy=0, digits 00:00, no done.
   - With DP_BLINK_EN, two sec_tick pulses → dp_n low on index 2 after the first pulse, high after the second.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the MM:SS seven-segment display stage.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV_MIN = 2'd1,
    CONV_SEC = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit code used for a field whose captured value was out of range.
  localparam logic [3:0] DIGIT_DASH = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment map.
// Codes 0-9 show the digit, 4'hF shows a dash, anything else is blank.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      DIGIT_DASH: seg = SEG_DASH;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_mux.sv
// MM:SS display stage: captures binary minutes/seconds, converts them to BCD by
// repeated subtract-10, and scans a 4-digit common-anode display. Optional
// colon blink on the digit-2 decimal point is enabled by defining DP_BLINK_EN.
module clock_display_mux
  import clock_disp_pkg::*;
#(
  parameter  int REFRESH_DIV = 50000,
  localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       sec_tick,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_n
);

  function automatic logic out_of_range(input logic [5:0] v);
    return v > 6'd59;
  endfunction

  // Clamping bounds an out-of-range field to the 59 cycle count (6 steps).
  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return out_of_range(v) ? 6'd59 : v;
  endfunction

  state_t state, state_nxt;

  logic [5:0] min_sh, sec_sh;
  logic [5:0] work, work_nxt;
  logic [3:0] tens, tens_nxt;
  logic [3:0] m_tens, m_ones, s_tens, s_ones;
  logic [3:0] m_tens_nxt, m_ones_nxt, s_tens_nxt, s_ones_nxt;
  logic       capture;

  // disp[3]=minutes tens, [2]=minutes ones, [1]=seconds tens, [0]=seconds ones
  logic [3:0][3:0] disp, disp_nxt;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic             wrap;
  logic [3:0]       digit_sel;
  logic [6:0]       seg_dec;

  assign capture = (state == IDLE) && load;
  assign busy    = (state == CONV_MIN) || (state == CONV_SEC);
  assign done    = (state == COMMIT);

  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    tens_nxt   = tens;
    m_tens_nxt = m_tens;
    m_ones_nxt = m_ones;
    s_tens_nxt = s_tens;
    s_ones_nxt = s_ones;
    disp_nxt   = disp;
    case (state)
      IDLE: begin
        if (load) begin
          work_nxt  = clamp59(minutes);
          tens_nxt  = 4'd0;
          state_nxt = CONV_MIN;
        end
      end
      CONV_MIN: begin
        if (work >= 6'd10) begin
          work_nxt = work - 6'd10;
          tens_nxt = tens + 4'd1;
        end else begin
          m_tens_nxt = out_of_range(min_sh) ? DIGIT_DASH : tens;
          m_ones_nxt = out_of_range(min_sh) ? DIGIT_DASH : work[3:0];
          work_nxt   = clamp59(sec_sh);
          tens_nxt   = 4'd0;
          state_nxt  = CONV_SEC;
        end
      end
      CONV_SEC: begin
        if (work >= 6'd10) begin
          work_nxt = work - 6'd10;
          tens_nxt = tens + 4'd1;
        end else begin
          s_tens_nxt = out_of_range(sec_sh) ? DIGIT_DASH : tens;
          s_ones_nxt = out_of_range(sec_sh) ? DIGIT_DASH : work[3:0];
          state_nxt  = COMMIT;
        end
      end
      COMMIT: begin
        disp_nxt  = {m_tens, m_ones, s_tens, s_ones};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      disp  <= '0;
    end else begin
      state <= state_nxt;
      disp  <= disp_nxt;
    end
  end

  // Conversion datapath: only read after being written in the same conversion.
  always_ff @(posedge clk) begin
    if (capture) begin
      min_sh <= minutes;
      sec_sh <= seconds;
    end
    work   <= work_nxt;
    tens   <= tens_nxt;
    m_tens <= m_tens_nxt;
    m_ones <= m_ones_nxt;
    s_tens <= s_tens_nxt;
    s_ones <= s_ones_nxt;
  end

  always_comb begin
    wrap    = (cnt == CNT_W'(REFRESH_DIV - 1));
    cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    idx_nxt = wrap ? idx + 2'd1 : idx;
  end

  // Decode from next-cycle digits so a commit reaches seg on the same edge.
  assign digit_sel = disp_nxt[idx_nxt];

  seg7_decode u_dec (
    .digit (digit_sel),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
      an  <= 4'b1110;
      seg <= SEG_0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      an  <= ~(4'b0001 << idx_nxt);
      seg <= seg_dec;
    end
  end

`ifdef DP_BLINK_EN
  logic colon, colon_nxt;

  assign colon_nxt = colon ^ sec_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colon <= 1'b0;
      dp_n  <= 1'b1;
    end else begin
      colon <= colon_nxt;
      dp_n  <= !((idx_nxt == 2'd2) && colon_nxt);
    end
  end
`else
  logic unused_sec_tick;

  assign unused_sec_tick = sec_tick;
  assign dp_n            = 1'b1;
`endif

endmodule

// File: tb/tb_clock_display_mux.sv
// Self-checking bench for clock_display_mux: table vectors, random loads
// against a decimal reference model, and hand-written multi-cycle sequences.
module tb_clock_display_mux;

  localparam int RDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       sec_tick = 1'b0;
  logic       busy, done, dp_n;
  logic [3:0] an;
  logic [6:0] seg;

  int tests = 0;
  int fails = 0;

  clock_display_mux #(.REFRESH_DIV(RDIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .minutes  (minutes),
    .seconds  (seconds),
    .sec_tick (sec_tick),
    .busy     (busy),
    .done     (done),
    .an       (an),
    .seg      (seg),
    .dp_n     (dp_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int s;
    int lat;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] field_seg(input int v, input bit tens_pos);
    if (v > 59) return 7'b0111111;
    return digit_seg(tens_pos ? v / 10 : v % 10);
  endfunction

  function automatic logic [6:0] model_seg(input int m, input int s, input int idx);
    case (idx)
      0: return field_seg(s, 1'b0);
      1: return field_seg(s, 1'b1);
      2: return field_seg(m, 1'b0);
      default: return field_seg(m, 1'b1);
    endcase
  endfunction

  function automatic int model_lat(input int m, input int s);
    int mm, ss;
    mm = (m > 59) ? 59 : m;
    ss = (s > 59) ? 59 : s;
    return (mm / 10 + 1) + (ss / 10 + 1) + 1;
  endfunction

  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] tgt, output bit found);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (an === tgt) found = 1'b1;
    end
  endtask

  task automatic check_display(input string tag, input int m, input int s);
    bit found;
    logic [3:0] one, tgt;
    one = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tgt = ~(one << i);
      wait_an(tgt, found);
      chk($sformatf("%s scan reaches idx%0d", tag, i), {31'd0, found}, 32'd1);
      chk($sformatf("%s seg idx%0d", tag, i), {25'd0, seg}, {25'd0, model_seg(m, s, i)});
    end
  endtask

  // Pulses load and watches 30 cycles; optionally fires a second load mid-conversion.
  task automatic run_conv(input int m, input int s, input bit inject,
                          output int lat, output int busy_n, output int done_n,
                          output logic [3:0] an_after, output logic [6:0] seg_after);
    lat = -1; busy_n = 0; done_n = 0; an_after = 4'hx; seg_after = 7'hx;
    @(negedge clk);
    load = 1'b1; minutes = 6'(m); seconds = 6'(s);
    @(negedge clk);
    load = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) lat = k;
      end
      if (lat > 0 && k == lat + 1) begin
        an_after = an;
        seg_after = seg;
      end
      if (inject && k == 3) begin
        load = 1'b1; minutes = 6'd45; seconds = 6'd30;
      end
      if (inject && k == 4) load = 1'b0;
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  initial begin
    int lat, busy_n, done_n, m, s, ai;
    logic [3:0] an_after;
    logic [6:0] seg_after;
    bit found;

    vecs[0] = '{m: 0,  s: 0,  lat: 3};
    vecs[1] = '{m: 59, s: 7,  lat: 8};
    vecs[2] = '{m: 59, s: 59, lat: 13};
    vecs[3] = '{m: 60, s: 0,  lat: 8};
    vecs[4] = '{m: 10, s: 63, lat: 9};
    vecs[5] = '{m: 9,  s: 10, lat: 4};

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset an", {28'd0, an}, 32'hE);
    chk("reset seg", {25'd0, seg}, 32'h40);
    chk("reset dp_n", {31'd0, dp_n}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Scan timing: each digit held RDIV clocks, index advancing 0..3..0
    for (int n = 1; n <= 20; n++) begin
      logic [3:0] one;
      @(negedge clk);
      one = 4'b0001;
      chk($sformatf("scan an cycle %0d", n), {28'd0, an},
          {28'd0, ~(one << ((n / RDIV) % 4))});
    end

    foreach (vecs[i]) begin
      m = vecs[i].m; s = vecs[i].s;
      run_conv(m, s, 1'b0, lat, busy_n, done_n, an_after, seg_after);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d done count", i), done_n, 1);
      chk($sformatf("vec%0d busy cycles", i), busy_n, vecs[i].lat - 1);
      ai = idx_of(an_after);
      chk($sformatf("vec%0d seg right after commit", i), {25'd0, seg_after},
          {25'd0, (ai < 0) ? 7'h7f : model_seg(m, s, ai)});
      check_display($sformatf("vec%0d", i), m, s);
    end

    // Load while busy is ignored
    run_conv(59, 7, 1'b1, lat, busy_n, done_n, an_after, seg_after);
    chk("busy-load latency", lat, 8);
    chk("busy-load done count", done_n, 1);
    check_display("busy-load", 59, 7);

    for (int r = 0; r < 12; r++) begin
      m = $urandom_range(0, 63);
      s = $urandom_range(0, 63);
      run_conv(m, s, 1'b0, lat, busy_n, done_n, an_after, seg_after);
      chk($sformatf("rand%0d %0d:%0d latency", r, m, s), lat, model_lat(m, s));
      chk($sformatf("rand%0d done count", r), done_n, 1);
      check_display($sformatf("rand%0d", r), m, s);
    end

    // Reset during CONV_SEC of a 59:59 conversion
    @(negedge clk);
    load = 1'b1; minutes = 6'd59; seconds = 6'd59;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-abort busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort an", {28'd0, an}, 32'hE);
    chk("abort seg", {25'd0, seg}, 32'h40);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("abort no done", done_n, 0);
    check_display("abort", 0, 0);

    // Colon flag on digit 2
    pulse_tick();
    wait_an(4'b1011, found);
    chk("tick1 reach idx2", {31'd0, found}, 32'd1);
`ifdef DP_BLINK_EN
    chk("tick1 dp_n idx2", {31'd0, dp_n}, 32'd0);
`else
    chk("tick1 dp_n idx2", {31'd0, dp_n}, 32'd1);
`endif
    wait_an(4'b1110, found);
    chk("tick1 dp_n idx0", {31'd0, dp_n}, 32'd1);
    pulse_tick();
    wait_an(4'b1011, found);
    chk("tick2 reach idx2", {31'd0, found}, 32'd1);
    chk("tick2 dp_n idx2", {31'd0, dp_n}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
